// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit, restoring shift-subtract
// The per-iteration 32-bit subtraction runs in an external DSP subtractor via the sub_* ports.
module iterative_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] sub_in1,
  output logic [31:0] sub_in2,
  input  logic [31:0] sub_out,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ITER  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [31:0] result_q;
  logic [4:0]  cnt_q;
  logic        neg_q_q;
  logic        neg_r_q;

  logic        div_by_zero;
  logic        overflow;
  logic        special;
  logic [31:0] shifted;
  logic        top;
  logic        borrow;
  logic        ge;

  // In SETUP quo_q/dvs_q still hold the raw operands captured at acceptance.
  assign div_by_zero = (dvs_q == 32'd0);
  assign overflow    = ~op_q[0] && (quo_q == 32'h8000_0000) && (dvs_q == 32'hFFFF_FFFF);
  assign special     = div_by_zero || overflow;

  // 33-bit partial remainder {top, shifted}; top set means it already exceeds any divisor.
  assign shifted = {rem_q[30:0], quo_q[31]};
  assign top     = rem_q[31];
  assign borrow  = (~shifted[31] & dvs_q[31]) | (~(shifted[31] ^ dvs_q[31]) & sub_out[31]);
  assign ge      = top | ~borrow;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SETUP;
      S_SETUP: state_nxt = special ? S_DONE : S_ITER;
      S_ITER:  if (cnt_q == 5'd0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    sub_in1 = (state == S_ITER) ? shifted : rem_q;
    sub_in2 = dvs_q;
    result  = result_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= 2'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      result_q <= 32'd0;
      cnt_q    <= 5'd0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            quo_q <= dividend;
            dvs_q <= divisor;
          end
        end
        S_SETUP: begin
          rem_q <= 32'd0;
          cnt_q <= 5'd31;
          if (!op_q[0]) begin
            quo_q   <= quo_q[31] ? -quo_q : quo_q;
            dvs_q   <= dvs_q[31] ? -dvs_q : dvs_q;
            neg_q_q <= quo_q[31] ^ dvs_q[31];
            neg_r_q <= quo_q[31];
          end else begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
          end
          if (div_by_zero) begin
            result_q <= op_q[1] ? quo_q : 32'hFFFF_FFFF;
          end else if (overflow) begin
            result_q <= op_q[1] ? 32'd0 : 32'h8000_0000;
          end
        end
        S_ITER: begin
          rem_q <= ge ? sub_out : shifted;
          quo_q <= {quo_q[30:0], ge};
          cnt_q <= cnt_q - 5'd1;
        end
        S_FIX: begin
          if (op_q[1]) begin
            result_q <= neg_r_q ? -rem_q : rem_q;
          end else begin
            result_q <= neg_q_q ? -quo_q : quo_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - scoreboard bench for iterative_divider against an arithmetic reference
// The external subtractor is modelled here as a plain combinational difference.
module tb_iterative_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] sub_in1;
  logic [31:0] sub_in2;
  logic [31:0] sub_out;
  logic        busy;
  logic        done;
  logic [31:0] result;

  iterative_divider dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .sub_in1  (sub_in1),
    .sub_in2  (sub_in2),
    .sub_out  (sub_out),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  assign sub_out = sub_in1 - sub_in2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
    longint sa, sd, q, r;
    if (d == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      sa = longint'($signed(a));
      sd = longint'($signed(d));
    end else begin
      sa = longint'({32'd0, a});
      sd = longint'({32'd0, d});
    end
    q = sa / sd;
    r = sa % sd;
    return o[1] ? r[31:0] : q[31:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d,
                        input bit distract, input bit rst20, input bit start_in_done);
    int lat;
    bit busy_ok;
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = d;
    lat = ((d == 32'd0) || (!o[0] && a == 32'h8000_0000 && d == 32'hFFFF_FFFF)) ? 2 : 35;
    exp_q.push_back('{ref_model(o, a, d), cyc + lat});
    busy_ok = 1'b1;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      start    = 1'b0;
      op       = 2'($urandom);
      dividend = $urandom;
      divisor  = $urandom;
      if (busy !== (k <= lat)) busy_ok = 1'b0;
      if (distract && k == 10) start = 1'b1;
      if (start_in_done && k == lat) start = 1'b1;
      if (rst20 && k == 20) begin
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_result", result, 32'd0);
        check("reset_done", done, 1'b0);
        reset = 1'b0;
        return;
      end
    end
    check("busy_profile", busy_ok, 1'b1);
    check("done_seen", exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rd;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'd0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 32'd0);
    check("rst_sub_in1", sub_in1, 32'd0);
    check("rst_sub_in2", sub_in2, 32'd0);
    reset = 1'b0;

    run_op(2'b01, 32'd100, 32'd7, 0, 0, 0);
    run_op(2'b11, 32'd100, 32'd7, 0, 0, 0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, 0, 0);
    run_op(2'b01, 32'h0000_002A, 32'd0, 0, 0, 0);
    run_op(2'b10, 32'h0000_002A, 32'd0, 0, 0, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 0, 0, 0);
    run_op(2'b01, 32'd100, 32'd7, 1, 0, 0);
    run_op(2'b00, 32'h1234_5678, 32'hFFFF_FF00, 0, 0, 1);
    run_op(2'b01, 32'd1000, 32'd3, 0, 1, 0);
    run_op(2'b01, 32'd1000, 32'd3, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000;
        1:       ra = $urandom_range(0, 255);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rd = 32'd0;
        1:       rd = 32'hFFFF_FFFF;
        2:       rd = $urandom_range(1, 15);
        3:       rd = 32'h8000_0000 | $urandom_range(0, 7);
        default: rd = $urandom;
      endcase
      run_op(ro, ra, rd, 0, 0, 0);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
